counting_sched: RTL and testbench
=================================

// Module: counting_sched
// PURPOSE
//   Shares one 4-state "1,2,3" symbol-sequence detector among NCH requesters.
//   - Round-robin arbiter grants one requester per cycle.
//   - Keeps one detector state register per channel.
//   - Steps the granted channel's state with its 2-bit symbol.
//   - Reports a hit when a channel completes 1,2,3.
//   - Sits between the symbol sources and the hit consumer.
// PARAMETERS
//   NCH    4  number of requester channels (2..16)
//   CW     $clog2(NCH)  channel index width (localparam, derived)
//   CNT_W  8  hit counter width (used only with COUNTING_HIT_CNT_EN)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      reset, synchronous, active-low
//   req_valid  in   NCH    channel i has a symbol pending
//   req_num    in   2*NCH  symbol for channel i at bits [2i+1:2i]
//   req_ready  out  NCH    one-hot grant (combinational); symbol consumed when valid&ready
//   clr_valid  in   1      clear one channel's detector state
//   clr_ch     in   CW     channel to clear
//   hit_valid  out  1      registered; channel just reached S3
//   hit_ch     out  CW     registered; channel index of the hit
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - all channel states go to S0; rr_ptr=0
//     - hit_valid=0, hit_ch=0
//     - while rst_n=0, req_ready is forced to 0
//   Arbitration:
//     - search from rr_ptr upward with wrap for the first channel with req_valid=1
//       that is not masked by a clear this cycle
//     - drive req_ready one-hot for that channel; all zeros if none qualifies
//     - on a grant, rr_ptr <= granted+1 (mod NCH); otherwise rr_ptr holds
//   Detector step for granted channel g with symbol n (next state):
//     S0: n==1 -> S1, else S0
//     S1: n==1 -> S1, n==2 -> S2, else S0
//     S2: n==3 -> S3, n==1 -> S1, else S0
//     S3: n==1 -> S1, else S0
//     state[g] is written at the same edge.
//   Latency: a grant in cycle T gives hit_valid=1, hit_ch=g in cycle T+1
//     iff next state == S3; otherwise hit_valid=0 in T+1. Back-to-back grants are allowed.
//   Clear:
//     - clr_valid=1 sets state[clr_ch] <= S0 at the edge
//     - clr_ch is masked from arbitration that cycle; its symbol is not consumed
//     - other channels arbitrate normally
//     - clr_ch >= NCH is ignored
//   Overlap: after S3, a 1 restarts at S1, so the stream 1,2,3,1,2,3 gives two hits.
// CONFIGURATION
//   COUNTING_HIT_CNT_EN defined:
//     - per-channel CNT_W-bit hit counter; increments on that channel's hit
//     - saturates at all-ones; reset/clear of the channel zeroes it
//     - extra ports: cnt_sel in CW; cnt_rdata out CNT_W (combinational read of counter[cnt_sel])
//   COUNTING_HIT_CNT_EN undefined: no counters and no cnt_* ports.
// STRUCTURE
//   Package counting_pkg:
//     - 2-bit state encodings S0=00, S1=01, S2=10, S3=11
//     - symbol constants SYM1..SYM3
//   Sub-module counting_step: combinational (state, num) -> (next, hit).
//   Top level holds the arbiter, the state array, rr_ptr and the output registers.
// TESTING
//   1 ch0 only, symbols 1,2,3 on consecutive cycles -> req_ready=0001 each cycle;
//     hit_valid=1, hit_ch=0 in the cycle after the 3.
//   2 ch0 and ch1 both valid every cycle, each stream 1,2,3 -> grants alternate 0,1,0,1,0,1;
//     hits ch0 then ch1 on consecutive cycles.
//   3 all 4 channels valid and held -> req_ready sequence 0001,0010,0100,1000,0001.
//   4 ch2 in S2; clr_valid=1, clr_ch=2 while ch2 is valid with 3 -> req_ready[2]=0;
//     state[2]=S0; no hit; a 3 on the next grant -> no hit.
//   5 ch0 in S2; rst_n=0 for 1 cycle, then 3 -> req_ready=0 during reset;
//     after reset, grant to ch0 with no hit; rr_ptr restarts at 0.
//   6 COUNTING_HIT_CNT_EN, CNT_W=8: 300 hits on ch1, cnt_sel=1 -> cnt_rdata=255;
//     clr ch1 -> cnt_rdata=0.

Source files
------------

// File: rtl/counting_pkg.sv
// Shared types and constants for the round-robin "1,2,3" sequence detector
// (counting_sched and counting_step).
package counting_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_e;

   localparam logic [1:0] SYM1 = 2'd1;
   localparam logic [1:0] SYM2 = 2'd2;
   localparam logic [1:0] SYM3 = 2'd3;

   // Modular add for channel indices; both operands are already below n.
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

// File: rtl/counting_step.sv
// Combinational next-state function of the shared "1,2,3" detector.
// hit_o flags a transition into S3.
module counting_step
   import counting_pkg::*;
(
   input  state_e     state_i,
   input  logic [1:0] num_i,
   output state_e     next_o,
   output logic       hit_o
);

   always_comb begin
      // NOTE: default assigned first so no path leaves next_o unassigned (no latch).
      next_o = S0;
      case (state_i)
         S0: if (num_i == SYM1) next_o = S1;
         S1: begin
            if (num_i == SYM1)      next_o = S1;
            else if (num_i == SYM2) next_o = S2;
         end
         S2: begin
            if (num_i == SYM3)      next_o = S3;
            else if (num_i == SYM1) next_o = S1;
         end
         S3: if (num_i == SYM1) next_o = S1;
         default: next_o = S0;
      endcase
   end

   assign hit_o = (next_o == S3);

endmodule

// File: rtl/counting_sched.sv
// Round-robin scheduler sharing one "1,2,3" detector among NCH channels.
// Optional per-channel saturating hit counters when COUNTING_HIT_CNT_EN is defined.
module counting_sched
   import counting_pkg::*;
#(
   parameter  int NCH   = 4,
   parameter  int CNT_W = 8,
   localparam int CW    = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   req_valid,
   input  logic [2*NCH-1:0] req_num,
   output logic [NCH-1:0]   req_ready,
   input  logic             clr_valid,
   input  logic [CW-1:0]    clr_ch,
   output logic             hit_valid,
   output logic [CW-1:0]    hit_ch
`ifdef COUNTING_HIT_CNT_EN
   ,
   input  logic [CW-1:0]    cnt_sel,
   output logic [CNT_W-1:0] cnt_rdata
`endif
);

   if (NCH < 2 || NCH > 16 || CNT_W < 1) begin : g_param_check
      $error("counting_sched: NCH must be 2..16 and CNT_W >= 1");
   end

   state_e           state_q [NCH];
   state_e           state_d [NCH];
   logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             hit_valid_q, hit_valid_d;
   logic [CW-1:0]    hit_ch_q, hit_ch_d;

   logic             clr_en;
   logic [NCH-1:0]   clr_mask, avail, grant_oh;
   logic [1:0]       sym_arr [NCH];
   logic [CW-1:0]    arb_idx, grant_ch;
   logic             grant_any;
   logic [1:0]       grant_sym;
   state_e           step_next;
   logic             step_hit;

   assign clr_en = clr_valid && (int'(clr_ch) < NCH);

   always_comb begin
      clr_mask = '0;
      if (clr_en) clr_mask[clr_ch] = 1'b1;
   end

   assign avail = req_valid & ~clr_mask;

   always_comb begin
      for (int i = 0; i < NCH; i++) sym_arr[i] = req_num[2*i +: 2];
   end

   // First qualifying channel at or after rr_ptr, wrapping around.
   always_comb begin
      grant_any = 1'b0;
      grant_ch  = '0;
      grant_oh  = '0;
      arb_idx   = '0;
      for (int k = 0; k < NCH; k++) begin
         arb_idx = CW'(wrap_add(int'(rr_ptr_q), k, NCH));
         if (!grant_any && avail[arb_idx]) begin
            grant_any         = 1'b1;
            grant_ch          = arb_idx;
            grant_oh[arb_idx] = 1'b1;
         end
      end
   end

   assign grant_sym = sym_arr[grant_ch];
   assign req_ready = rst_n ? grant_oh : '0;

   counting_step u_step (
      .state_i (state_q[grant_ch]),
      .num_i   (grant_sym),
      .next_o  (step_next),
      .hit_o   (step_hit)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      hit_valid_d = grant_any && step_hit;
      hit_ch_d    = hit_ch_q;
      if (grant_any) begin
         state_d[grant_ch] = step_next;
         rr_ptr_d          = CW'(wrap_add(int'(grant_ch), 1, NCH));
         if (step_hit) hit_ch_d = grant_ch;
      end
      if (clr_en) state_d[clr_ch] = S0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the state array is reset because every channel must restart in S0.
         for (int i = 0; i < NCH; i++) state_q[i] <= S0;
         rr_ptr_q    <= '0;
         hit_valid_q <= 1'b0;
         hit_ch_q    <= '0;
      end else begin
         // NOTE: non-blocking for all registered state; blocking only in always_comb.
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         hit_valid_q <= hit_valid_d;
         hit_ch_q    <= hit_ch_d;
      end
   end

   assign hit_valid = hit_valid_q;
   assign hit_ch    = hit_ch_q;

`ifdef COUNTING_HIT_CNT_EN
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];

   // Saturating count; a cleared channel is never granted in the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (grant_any && step_hit && (cnt_q[grant_ch] != '1))
         cnt_d[grant_ch] = cnt_q[grant_ch] + 1'b1;
      if (clr_en) cnt_d[clr_ch] = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_rdata = (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_counting_sched.sv
// Scoreboard bench for counting_sched (NCH=4): directed symbol streams with
// hand-computed grants and hits; counter checks when COUNTING_HIT_CNT_EN is defined.
module tb_counting_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_valid;
   logic [7:0] req_num;
   logic [3:0] req_ready;
   logic       clr_valid;
   logic [1:0] clr_ch;
   logic       hit_valid;
   logic [1:0] hit_ch;
`ifdef COUNTING_HIT_CNT_EN
   logic [1:0] cnt_sel;
   logic [7:0] cnt_rdata;
`endif

   int    n_vec = 0;
   int    n_err = 0;
   string cur_test = "init";

   logic [3:0] rdy_q [$];
   logic [1:0] hit_q [$];

   always #5 clk = ~clk;

   counting_sched #(.NCH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_num   (req_num),
      .req_ready (req_ready),
      .clr_valid (clr_valid),
      .clr_ch    (clr_ch),
      .hit_valid (hit_valid),
      .hit_ch    (hit_ch)
`ifdef COUNTING_HIT_CNT_EN
      ,
      .cnt_sel   (cnt_sel),
      .cnt_rdata (cnt_rdata)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", cur_test, name, act, exp);
      end
   endtask

   // Monitor: one grant expectation per driven cycle; one hit expectation per hit seen.
   always @(negedge clk) begin
      if (rdy_q.size() > 0) check("req_ready", 32'(req_ready), 32'(rdy_q.pop_front()));
      if (hit_valid === 1'b1) begin
         if (hit_q.size() == 0) check("unexpected_hit", 32'(hit_valid), 32'd0);
         else                   check("hit_ch", 32'(hit_ch), 32'(hit_q.pop_front()));
      end
   end

   task automatic cyc(input logic [3:0] v, input logic [7:0] n, input logic cv,
                      input logic [1:0] cc, input logic [3:0] exp_rdy,
                      input logic exp_hit, input logic [1:0] exp_ch);
      req_valid = v;
      req_num   = n;
      clr_valid = cv;
      clr_ch    = cc;
      rdy_q.push_back(exp_rdy);
      if (exp_hit) hit_q.push_back(exp_ch);
      @(posedge clk);
      #1;
   endtask

   task automatic sym(input logic [3:0] v, input logic [7:0] n, input logic [3:0] exp_rdy,
                      input logic exp_hit, input logic [1:0] exp_ch);
      cyc(v, n, 1'b0, 2'd0, exp_rdy, exp_hit, exp_ch);
   endtask

   task automatic idle();
      cyc(4'h0, 8'h00, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(4'hF, 8'hFF, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0);
      rst_n = 1'b1;
      check("reset_hit_valid", 32'(hit_valid), 32'd0);
      check("reset_hit_ch", 32'(hit_ch), 32'd0);
   endtask

   logic [1:0] ov_sym [19] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3,
                               2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
   logic       ov_hit [19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_num   = '0;
      clr_valid = 1'b0;
      clr_ch    = '0;
`ifdef COUNTING_HIT_CNT_EN
      cnt_sel   = '0;
`endif
      @(posedge clk);
      #1;

      cur_test = "single_ch0";
      do_reset();
      sym(4'b0001, 8'h01, 4'b0001, 1'b0, 2'd0);
      sym(4'b0001, 8'h02, 4'b0001, 1'b0, 2'd0);
      sym(4'b0001, 8'h03, 4'b0001, 1'b1, 2'd0);
      idle();

      cur_test = "two_ch_alternate";
      do_reset();
      sym(4'b0011, 8'h05, 4'b0001, 1'b0, 2'd0);
      sym(4'b0011, 8'h06, 4'b0010, 1'b0, 2'd0);
      sym(4'b0011, 8'h0A, 4'b0001, 1'b0, 2'd0);
      sym(4'b0011, 8'h0B, 4'b0010, 1'b0, 2'd0);
      sym(4'b0011, 8'h0F, 4'b0001, 1'b1, 2'd0);
      sym(4'b0011, 8'h0C, 4'b0010, 1'b1, 2'd1);
      idle();

      cur_test = "four_ch_rotate";
      do_reset();
      sym(4'b1111, 8'h00, 4'b0001, 1'b0, 2'd0);
      sym(4'b1111, 8'h00, 4'b0010, 1'b0, 2'd0);
      sym(4'b1111, 8'h00, 4'b0100, 1'b0, 2'd0);
      sym(4'b1111, 8'h00, 4'b1000, 1'b0, 2'd0);
      sym(4'b1111, 8'h00, 4'b0001, 1'b0, 2'd0);
      idle();

      cur_test = "clear_masks_ch2";
      do_reset();
      sym(4'b0100, 8'h10, 4'b0100, 1'b0, 2'd0);
      sym(4'b0100, 8'h20, 4'b0100, 1'b0, 2'd0);
      cyc(4'b0101, 8'h30, 1'b1, 2'd2, 4'b0001, 1'b0, 2'd0);
      sym(4'b0100, 8'h30, 4'b0100, 1'b0, 2'd0);
      idle();

      cur_test = "reset_midstream";
      do_reset();
      sym(4'b0001, 8'h01, 4'b0001, 1'b0, 2'd0);
      sym(4'b0001, 8'h02, 4'b0001, 1'b0, 2'd0);
      rst_n = 1'b0;
      sym(4'b0001, 8'h03, 4'b0000, 1'b0, 2'd0);
      rst_n = 1'b1;
      check("post_reset_hit_valid", 32'(hit_valid), 32'd0);
      sym(4'b0011, 8'h03, 4'b0001, 1'b0, 2'd0);
      idle();

      cur_test = "overlap_ch3";
      do_reset();
      for (int i = 0; i < 19; i++)
         sym(4'b1000, {ov_sym[i], 6'b0}, 4'b1000, ov_hit[i], 2'd3);
      idle();

`ifdef COUNTING_HIT_CNT_EN
      cur_test = "hit_counter";
      do_reset();
      cnt_sel = 2'd1;
      for (int i = 0; i < 300; i++) begin
         sym(4'b0010, 8'h04, 4'b0010, 1'b0, 2'd0);
         sym(4'b0010, 8'h08, 4'b0010, 1'b0, 2'd0);
         sym(4'b0010, 8'h0C, 4'b0010, 1'b1, 2'd1);
         if (i == 2) check("cnt_after_3", 32'(cnt_rdata), 32'd3);
      end
      idle();
      check("cnt_saturated", 32'(cnt_rdata), 32'd255);
      cnt_sel = 2'd0;
      #1;
      check("cnt_other_ch", 32'(cnt_rdata), 32'd0);
      cnt_sel = 2'd1;
      cyc(4'b0000, 8'h00, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0);
      check("cnt_cleared", 32'(cnt_rdata), 32'd0);
      idle();
`endif

      cur_test = "drain";
      check("hit_queue_drained", 32'(hit_q.size()), 32'd0);
      check("grant_queue_drained", 32'(rdy_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
